calc_stream_controller: RTL and testbench

Parametrised next-generation calculator controller.
- Streams operand pairs from SRAM over an inclusive address range and applies add or subtract per pair.
- Packs PACK results into one write word and writes it to a bounded destination range.
- Adds a start/done handshake, configurable read latency, an overflow flag and range-error reporting.
- Sits between the SRAM read/write ports and the testbench/top-level sequencer.

---
 rtl/calc_stream_controller_pkg.sv | 27 ++
 rtl/calc_stream_controller_result_packer.sv | 57 +++++
 rtl/calc_stream_controller.sv | 177 +++++++++++++++++
 tb/tb_calc_stream_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_stream_controller_pkg.sv
// Shared definitions for the streaming calculator controller: default
// widths, FSM state encoding, arithmetic mode and a lane-index helper.
package calculator_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_t;

  // Width of a lane index; a single-lane packer still needs one bit.
  function automatic int lane_w(input int pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

endpackage

// File: rtl/calc_stream_controller_result_packer.sv
// Collects PACK results into one write word. The first result of a group
// lands in the most-significant lane; unfilled lanes stay zero.
module result_packer
  import calculator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PACK   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic                   full_o,
  output logic [PACK*DATA_W-1:0] word_o
);

  localparam int LANE_W = lane_w(PACK);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] buf_q [PACK];
  logic [DATA_W-1:0] buf_d [PACK];

  // High when the next load fills the last lane of the word.
  assign full_o = (lane_q == LAST_LANE);

  // Lane pointer and lane contents; clear takes priority over load.
  always_comb begin
    lane_d = lane_q;
    buf_d  = buf_q;
    if (clear_i) begin
      lane_d = '0;
      for (int i = 0; i < PACK; i++) buf_d[i] = '0;
    end else if (load_i) begin
      buf_d[lane_q] = data_i;
      lane_d        = full_o ? '0 : lane_q + 1'b1;
    end
  end

  // Lane pointer and buffer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lane_q <= '0;
      for (int i = 0; i < PACK; i++) buf_q[i] <= '0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
    end
  end

  // Lane 0 is the most-significant slice of the output word.
  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign word_o[(PACK-1-gi)*DATA_W +: DATA_W] = buf_q[gi];
  end

endmodule

// File: rtl/calc_stream_controller.sv
// Streams operand pairs from SRAM, adds or subtracts each pair, packs the
// results and writes them into a bounded destination range.
module calc_stream_controller
  import calculator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PACK   = 2,
  parameter int RD_LAT = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [ADDR_W-1:0]      read_start_addr,
  input  logic [ADDR_W-1:0]      read_end_addr,
  input  logic [ADDR_W-1:0]      write_start_addr,
  input  logic [ADDR_W-1:0]      write_end_addr,
  output logic                   read_n_o,
  output logic [ADDR_W-1:0]      r_addr_o,
  input  logic [2*DATA_W-1:0]    r_data_i,
  output logic                   write_n_o,
  output logic [ADDR_W-1:0]      w_addr_o,
  output logic [PACK*DATA_W-1:0] w_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic                   err_o
);

  // Last wait-counter value before the read data is valid.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

  state_t                   state_q, state_d;
  mode_t                    mode_q, mode_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d, rd_end_q, rd_end_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d, wr_end_q, wr_end_d;
  logic [1:0]               wait_q, wait_d;
  logic                     last_rd_q, last_rd_d;
  logic                     ovf_q, ovf_d, err_q, err_d;
  logic [PACK*DATA_W-1:0]   w_data_q, w_data_d;

  logic                     pk_clear, pk_load, pk_full;
  logic [PACK*DATA_W-1:0]   pk_word;
  logic [DATA_W-1:0]        op_a, op_b;
  logic [DATA_W:0]          result;

  assign op_a = r_data_i[2*DATA_W-1:DATA_W];
  assign op_b = r_data_i[DATA_W-1:0];

  // The extra top bit is the carry for add and the borrow for subtract.
  assign result = (mode_q == MODE_SUB) ? ({1'b0, op_a} - {1'b0, op_b})
                                       : ({1'b0, op_a} + {1'b0, op_b});

  result_packer #(
    .DATA_W(DATA_W),
    .PACK  (PACK)
  ) u_packer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(pk_clear),
    .load_i (pk_load),
    .data_i (result[DATA_W-1:0]),
    .full_o (pk_full),
    .word_o (pk_word)
  );

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rd_addr_d = rd_addr_q;
    rd_end_d  = rd_end_q;
    wr_addr_d = wr_addr_q;
    wr_end_d  = wr_end_q;
    wait_d    = wait_q;
    last_rd_d = last_rd_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    w_data_d  = w_data_q;
    pk_clear  = 1'b0;
    pk_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d    = mode_t'(mode_i);
          rd_addr_d = read_start_addr;
          rd_end_d  = read_end_addr;
          wr_addr_d = write_start_addr;
          wr_end_d  = write_end_addr;
          last_rd_d = 1'b0;
          ovf_d     = 1'b0;
          err_d     = 1'b0;
          pk_clear  = 1'b1;
          if ((read_start_addr > read_end_addr) ||
              (write_start_addr > write_end_addr)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        wait_d  = '0;
        state_d = (RD_LAT == 1) ? S_EXEC : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_EXEC;
        else                     wait_d  = wait_q + 2'd1;
      end
      S_EXEC: begin
        pk_load   = 1'b1;
        ovf_d     = ovf_q | result[DATA_W];
        rd_addr_d = rd_addr_q + 1'b1;
        last_rd_d = (rd_addr_q == rd_end_q);
        state_d   = (pk_full || (rd_addr_q == rd_end_q)) ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        pk_clear  = 1'b1;
        w_data_d  = pk_word;
        wr_addr_d = wr_addr_q + 1'b1;
        if (last_rd_q) begin
          state_d = S_DONE;
        end else if (wr_addr_q == wr_end_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_ADD;
      rd_addr_q <= '0;
      rd_end_q  <= '0;
      wr_addr_q <= '0;
      wr_end_q  <= '0;
      wait_q    <= '0;
      last_rd_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      w_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rd_addr_q <= rd_addr_d;
      rd_end_q  <= rd_end_d;
      wr_addr_q <= wr_addr_d;
      wr_end_q  <= wr_end_d;
      wait_q    <= wait_d;
      last_rd_q <= last_rd_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      w_data_q  <= w_data_d;
    end
  end

  // Write strobe is also gated by reset so an aborted run never writes.
  assign read_n_o   = (state_q != S_READ);
  assign write_n_o  = !((state_q == S_WRITE) && rst_ni);
  assign r_addr_o   = rd_addr_q;
  assign w_addr_o   = wr_addr_q;
  assign w_data_o   = (state_q == S_WRITE) ? pk_word : w_data_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign overflow_o = ovf_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_calc_stream_controller.sv
// Bench for calc_stream_controller: one instance with RD_LAT=1 and one with
// RD_LAT=3 run the same commands against a shared operand memory.
module tb_calc_stream_controller;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int PK    = 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [2*DW-1:0] JUNK = 64'hA5A5_5A5A_C3C3_3C3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, mode;
  logic [AW-1:0] rs, re, ws, we;

  logic             rd_n [2];
  logic             wr_n [2];
  logic             busy [2];
  logic             done [2];
  logic             ovf  [2];
  logic             err  [2];
  logic [AW-1:0]    ra   [2];
  logic [AW-1:0]    wa   [2];
  logic [PK*DW-1:0] wd   [2];
  logic [2*DW-1:0]  pipe [2][3];
  logic [2*DW-1:0]  rmem [DEPTH];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    calc_stream_controller #(
      .DATA_W(DW), .ADDR_W(AW), .PACK(PK), .RD_LAT(LAT)
    ) u_dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (start),
      .mode_i          (mode),
      .read_start_addr (rs),
      .read_end_addr   (re),
      .write_start_addr(ws),
      .write_end_addr  (we),
      .read_n_o        (rd_n[gi]),
      .r_addr_o        (ra[gi]),
      .r_data_i        (pipe[gi][LAT-1]),
      .write_n_o       (wr_n[gi]),
      .w_addr_o        (wa[gi]),
      .w_data_o        (wd[gi]),
      .busy_o          (busy[gi]),
      .done_o          (done[gi]),
      .overflow_o      (ovf[gi]),
      .err_o           (err[gi])
    );
  end

  typedef struct {
    int               k;
    int               a;
    logic [PK*DW-1:0] d;
  } wr_t;

  wr_t wlog[$];
  int  nrd [2];

  // SRAM model: read data appears RD_LAT edges after the read strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][2] <= pipe[k][1];
      pipe[k][1] <= pipe[k][0];
      pipe[k][0] <= (rd_n[k] == 1'b0) ? rmem[ra[k]] : JUNK;
      if (rd_n[k] == 1'b0) nrd[k] <= nrd[k] + 1;
      if (wr_n[k] == 1'b0) wlog.push_back('{k, int'(wa[k]), wd[k]});
    end
  end

  int total = 0;
  int bad   = 0;
  int base_w;
  int base_r [2];
  int cyc    [2];

  // Reference results for one command.
  int               exp_a[$];
  logic [PK*DW-1:0] exp_d[$];
  logic             exp_ovf, exp_err;
  int               exp_nrd;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Behavioural model: list of operands, grouped into words, truncated to the
  // number of words the destination range can hold.
  function automatic void model(input logic m, input int a_rs, a_re, a_ws, a_we);
    int n, groups, maxw, used;
    logic [PK*DW-1:0] word;
    exp_a.delete();
    exp_d.delete();
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    exp_nrd = 0;
    if (a_rs > a_re || a_ws > a_we) begin
      exp_err = 1'b1;
      return;
    end
    n      = a_re - a_rs + 1;
    groups = (n + PK - 1) / PK;
    maxw   = a_we - a_ws + 1;
    used   = n;
    if (groups > maxw) begin
      exp_err = 1'b1;
      used    = maxw * PK;
    end
    exp_nrd = used;
    word    = '0;
    for (int i = 0; i < used; i++) begin
      longint unsigned x, y, r;
      x = rmem[a_rs+i][2*DW-1:DW];
      y = rmem[a_rs+i][DW-1:0];
      if (m) begin
        r = x - y;
        if (x < y) exp_ovf = 1'b1;
      end else begin
        r = x + y;
        if (r >= 64'h1_0000_0000) exp_ovf = 1'b1;
      end
      word[(PK-1-(i%PK))*DW +: DW] = r[DW-1:0];
      if ((i % PK == PK - 1) || (i == used - 1)) begin
        exp_a.push_back(a_ws + i / PK);
        exp_d.push_back(word);
        word = '0;
      end
    end
  endfunction

  task automatic do_run(input logic m, input int a_rs, a_re, a_ws, a_we);
    base_w    = wlog.size();
    base_r[0] = nrd[0];
    base_r[1] = nrd[1];
    mode  = m;
    rs    = AW'(a_rs);
    re    = AW'(a_re);
    ws    = AW'(a_ws);
    we    = AW'(a_we);
    start = 1'b1;
    cyc[0] = -1;
    cyc[1] = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done[0] && cyc[0] < 0) cyc[0] = c;
      if (done[1] && cyc[1] < 0) cyc[1] = c;
      if (cyc[0] >= 0 && cyc[1] >= 0) break;
    end
    @(posedge clk);
    #1;
    $display("run mode=%0d rd=%0d..%0d wr=%0d..%0d cycles=%0d/%0d writes=%0d",
             m, a_rs, a_re, a_ws, a_we, cyc[0], cyc[1], wlog.size() - base_w);
  endtask

  // Compare both instances against the reference model.
  task automatic check_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      int lat, got_n;
      lat   = (k == 0) ? 1 : 3;
      got_n = 0;
      chk($sformatf("%s_d%0d_cyc", tag, k), cyc[k], exp_nrd * (1 + lat) + exp_a.size() + 1);
      chk($sformatf("%s_d%0d_ovf", tag, k), ovf[k], exp_ovf);
      chk($sformatf("%s_d%0d_err", tag, k), err[k], exp_err);
      chk($sformatf("%s_d%0d_nrd", tag, k), nrd[k] - base_r[k], exp_nrd);
      for (int j = base_w; j < wlog.size(); j++) begin
        if (wlog[j].k == k) begin
          if (got_n < exp_a.size()) begin
            chk($sformatf("%s_d%0d_wa%0d", tag, k, got_n), wlog[j].a, exp_a[got_n]);
            chk($sformatf("%s_d%0d_wd%0d", tag, k, got_n), wlog[j].d, exp_d[got_n]);
          end
          got_n++;
        end
      end
      chk($sformatf("%s_d%0d_nw", tag, k), got_n, exp_a.size());
    end
  endtask

  function automatic logic [63:0] first_word(input int k);
    for (int j = base_w; j < wlog.size(); j++)
      if (wlog[j].k == k) return wlog[j].d;
    return 'x;
  endfunction

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_d%0d_ctl", tag, k),
          {rd_n[k], wr_n[k], busy[k], done[k], ovf[k], err[k]}, 6'b110000);
      chk($sformatf("%s_d%0d_raddr", tag, k), ra[k], 0);
      chk($sformatf("%s_d%0d_waddr", tag, k), wa[k], 0);
      chk($sformatf("%s_d%0d_wdata", tag, k), wd[k], 0);
    end
  endtask

  typedef struct {
    logic        m;
    int          rs, re, ws, we;
    int          cyc1;
    logic        ovf;
    logic        err;
    int          nw;
    logic [63:0] w0;
  } vec_t;

  vec_t vecs [8];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    rs = '0; re = '0; ws = '0; we = '0;

    for (int a = 0; a < DEPTH; a++) rmem[a] = '0;
    rmem[0]    = {32'd1, 32'd2};
    rmem[1]    = {32'd3, 32'd4};
    rmem[2]    = {32'd5, 32'd6};
    rmem[3]    = {32'd7, 32'd8};
    rmem[4]    = {32'd5, 32'd7};
    rmem[5]    = {32'd9, 32'd10};
    rmem[8]    = {32'hFFFF_FFFF, 32'd1};
    rmem[9]    = {32'd1, 32'd1};
    rmem[1022] = {32'd10, 32'd20};
    rmem[1023] = {32'd100, 32'd200};
    for (int a = 100; a < 220; a++) rmem[a] = {$urandom, $urandom};

    // mode, rd range, wr range, cycles (RD_LAT=1), ovf, err, words, first word
    vecs[0] = '{1'b0, 0, 3, 16, 17, 11, 1'b0, 1'b0, 2, 64'h00000003_00000007};
    vecs[1] = '{1'b1, 4, 4, 20, 20, 4, 1'b1, 1'b0, 1, 64'hFFFFFFFE_00000000};
    vecs[2] = '{1'b0, 8, 9, 24, 25, 6, 1'b1, 1'b0, 1, 64'h00000000_00000002};
    vecs[3] = '{1'b0, 0, 5, 30, 31, 11, 1'b0, 1'b1, 2, 64'h00000003_00000007};
    vecs[4] = '{1'b0, 5, 2, 40, 41, 1, 1'b0, 1'b1, 0, 64'h0};
    vecs[5] = '{1'b0, 0, 1, 42, 41, 1, 1'b0, 1'b1, 0, 64'h0};
    vecs[6] = '{1'b0, 1022, 1023, 50, 50, 6, 1'b0, 1'b0, 1, 64'h0000001E_0000012C};
    vecs[7] = '{1'b1, 0, 2, 60, 61, 9, 1'b1, 1'b0, 2, 64'hFFFFFFFF_FFFFFFFF};

    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: table expectations plus full model check.
    for (int i = 0; i < 8; i++) begin
      do_run(vecs[i].m, vecs[i].rs, vecs[i].re, vecs[i].ws, vecs[i].we);
      model(vecs[i].m, vecs[i].rs, vecs[i].re, vecs[i].ws, vecs[i].we);
      check_model($sformatf("v%0d", i));
      chk($sformatf("v%0d_tbl_cyc", i), cyc[0], vecs[i].cyc1);
      chk($sformatf("v%0d_tbl_ovf", i), ovf[0], vecs[i].ovf);
      chk($sformatf("v%0d_tbl_err", i), err[0], vecs[i].err);
      chk($sformatf("v%0d_tbl_nw", i), exp_a.size(), vecs[i].nw);
      if (vecs[i].nw > 0) chk($sformatf("v%0d_tbl_w0", i), first_word(0), vecs[i].w0);
    end

    // Reset during the second EXEC of a run aborts it without writing.
    base_w = wlog.size();
    mode = 1'b0; rs = 10'd0; re = 10'd3; ws = 10'd16; we = 10'd17;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy[0], 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("abort");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_nowrite", wlog.size() - base_w, 0);
    chk("abort_idle", {busy[0], busy[1]}, 2'b00);
    do_run(1'b0, 0, 3, 16, 17);
    model(1'b0, 0, 3, 16, 17);
    check_model("restart");

    // Start held high: accepted again in the idle cycle right after done.
    mode = 1'b0; rs = 10'd5; re = 10'd2; ws = 10'd0; we = 10'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_done1", {done[0], done[1]}, 2'b11);
    @(posedge clk);
    #1;
    chk("b2b_idle", {done[0], done[1], busy[0], busy[1]}, 4'b0000);
    @(posedge clk);
    #1;
    chk("b2b_done2", {done[0], done[1], err[0], err[1]}, 4'b1111);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Randomised commands against the model.
    for (int t = 0; t < 12; t++) begin
      int   r_s, r_e, w_s, w_e;
      logic m;
      m   = 1'($urandom_range(0, 1));
      r_s = $urandom_range(100, 200);
      r_e = r_s + $urandom_range(0, 8);
      w_s = $urandom_range(300, 400);
      w_e = w_s + $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) r_e = r_s - 1;
      do_run(m, r_s, r_e, w_s, w_e);
      model(m, r_s, r_e, w_s, w_e);
      check_model($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
